// File: rtl/tc_sram_arbiter_pkg.sv
// Shared types and width helpers for the tc_sram arbiter and its round-robin selector.
package tc_sram_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tc_sram.sv
// Behavioural single-bank SRAM macro: byte-masked writes, reads delivered Latency cycles after the request.
module tc_sram #(
    parameter int NumWords  = 1024,
    parameter int DataWidth = 32,
    parameter int ByteWidth = 8,
    parameter int NumPorts  = 1,
    parameter int Latency   = 1,
    localparam int AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    localparam int BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumPorts-1:0]                 req_i,
    input  logic [NumPorts-1:0]                 we_i,
    input  logic [NumPorts-1:0][AddrWidth-1:0]  addr_i,
    input  logic [NumPorts-1:0][DataWidth-1:0]  wdata_i,
    input  logic [NumPorts-1:0][BeWidth-1:0]    be_i,
    output logic [NumPorts-1:0][DataWidth-1:0]  rdata_o
);

    logic [DataWidth-1:0] r_mem   [NumWords];
    logic [DataWidth-1:0] r_rdata [Latency];

    always_ff @(posedge clk_i) begin
        if (req_i[0] && we_i[0]) begin
            for (int k = 0; k < DataWidth; k++) begin
                if (be_i[0][k / ByteWidth]) begin
                    r_mem[addr_i[0]][k] <= wdata_i[0][k];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Latency; i++) begin
                r_rdata[i] <= '0;
            end
        end else begin
            if (req_i[0] && !we_i[0]) begin
                r_rdata[0] <= r_mem[addr_i[0]];
            end
            for (int i = 1; i < Latency; i++) begin
                r_rdata[i] <= r_rdata[i-1];
            end
        end
    end

    assign rdata_o[0] = r_rdata[Latency-1];

endmodule

// File: rtl/tc_sram_rr_select.sv
// Round-robin pick: lowest rotated distance from the priority pointer wins; one-hot grant plus its index.
module tc_sram_rr_select
    import tc_sram_arbiter_pkg::*;
#(
    parameter int NumReq = 4,
    localparam int IdWidth = id_width(NumReq)
) (
    input  logic [NumReq-1:0]  i_req,
    input  logic [IdWidth-1:0] i_ptr,
    output logic [NumReq-1:0]  o_gnt,
    output logic [IdWidth-1:0] o_idx,
    output logic               o_any
);

    always_comb begin
        int w_dist;
        int w_best;
        w_dist = 0;
        w_best = NumReq;
        o_idx  = '0;
        for (int j = 0; j < NumReq; j++) begin
            w_dist = (j + NumReq - int'(i_ptr)) % NumReq;
            if (i_req[j] && (w_dist < w_best)) begin
                w_best = w_dist;
                o_idx  = IdWidth'(j);
            end
        end
        o_any = (w_best < NumReq);
        o_gnt = '0;
        for (int j = 0; j < NumReq; j++) begin
            o_gnt[j] = o_any && (o_idx == IdWidth'(j));
        end
    end

endmodule

// File: rtl/tc_sram_arbiter.sv
// Round-robin sharing of one single-port tc_sram among NumReq masters, with a zero-fill pass after reset.
module tc_sram_arbiter
    import tc_sram_arbiter_pkg::*;
#(
    parameter int   NumReq    = 4,
    parameter int   NumWords  = 1024,
    parameter int   DataWidth = 64,
    parameter int   ByteWidth = 8,
    parameter int   Latency   = 1,
    parameter logic InitZero  = 1'b1,
    localparam int  AddrWidth = id_width(NumWords),
    localparam int  BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumReq-1:0]             req_i,
    input  logic [NumReq-1:0]             we_i,
    input  logic [NumReq*AddrWidth-1:0]   addr_i,
    input  logic [NumReq*DataWidth-1:0]   wdata_i,
    input  logic [NumReq*BeWidth-1:0]     be_i,
    output logic [NumReq-1:0]             gnt_o,
    output logic [NumReq-1:0]             rvalid_o,
    output logic [DataWidth-1:0]          rdata_o,
    output logic                          init_done_o
);

    localparam int IdWidth = id_width(NumReq);
    localparam logic [AddrWidth-1:0] LastWord = AddrWidth'(NumWords - 1);
    localparam logic [IdWidth-1:0]   LastId   = IdWidth'(NumReq - 1);

    state_e               r_state;
    logic [AddrWidth-1:0] r_init_cnt;
    logic                 r_init_done;
    logic [IdWidth-1:0]   r_ptr;
    logic [Latency-1:0]   r_pipe_vld;
    logic [IdWidth-1:0]   r_pipe_id [Latency];

    logic [NumReq-1:0]    w_sel_gnt;
    logic [IdWidth-1:0]   w_sel_idx;
    logic                 w_sel_any;
    logic                 w_run;
    logic                 w_grant;
    logic [IdWidth-1:0]   w_next_ptr;
    logic                 w_sram_req;
    logic                 w_sram_we;
    logic [AddrWidth-1:0] w_sram_addr;
    logic [DataWidth-1:0] w_sram_wdata;
    logic [BeWidth-1:0]   w_sram_be;
    logic [DataWidth-1:0] w_sram_rdata;

    tc_sram_rr_select #(
        .NumReq (NumReq)
    ) u_select (
        .i_req (req_i),
        .i_ptr (r_ptr),
        .o_gnt (w_sel_gnt),
        .o_idx (w_sel_idx),
        .o_any (w_sel_any)
    );

    assign w_run      = (r_state == ST_RUN);
    assign w_grant    = w_run && w_sel_any;
    assign gnt_o      = w_run ? w_sel_gnt : '0;
    assign w_next_ptr = (w_sel_idx == LastId) ? '0 : w_sel_idx + 1'b1;

    // While clearing, the sequencer owns the port; afterwards the granted master does.
    always_comb begin
        w_sram_req   = 1'b1;
        w_sram_we    = 1'b1;
        w_sram_addr  = r_init_cnt;
        w_sram_wdata = '0;
        w_sram_be    = '1;
        if (w_run) begin
            w_sram_req   = w_grant;
            w_sram_we    = 1'b0;
            w_sram_addr  = '0;
            w_sram_be    = '0;
            for (int i = 0; i < NumReq; i++) begin
                if (w_sel_gnt[i]) begin
                    w_sram_we    = we_i[i];
                    w_sram_addr  = addr_i[i*AddrWidth +: AddrWidth];
                    w_sram_wdata = wdata_i[i*DataWidth +: DataWidth];
                    w_sram_be    = be_i[i*BeWidth +: BeWidth];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= InitZero ? ST_INIT : ST_RUN;
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
            r_ptr       <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (r_init_cnt == LastWord) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end else begin
                        r_init_cnt <= r_init_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    r_init_done <= 1'b1;
                    if (w_sel_any) begin
                        r_ptr <= w_next_ptr;
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    // Response tags ride alongside the SRAM read pipe so rvalid lines up with rdata.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pipe_vld <= '0;
        end else begin
            r_pipe_vld[0] <= w_grant;
            for (int i = 1; i < Latency; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        r_pipe_id[0] <= w_sel_idx;
        for (int i = 1; i < Latency; i++) begin
            r_pipe_id[i] <= r_pipe_id[i-1];
        end
    end

    always_comb begin
        rvalid_o = '0;
        for (int i = 0; i < NumReq; i++) begin
            rvalid_o[i] = r_pipe_vld[Latency-1] && (r_pipe_id[Latency-1] == IdWidth'(i));
        end
    end

    assign rdata_o     = w_sram_rdata;
    assign init_done_o = r_init_done;

    tc_sram #(
        .NumWords  (NumWords),
        .DataWidth (DataWidth),
        .ByteWidth (ByteWidth),
        .NumPorts  (1),
        .Latency   (Latency)
    ) u_sram (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req_i   (w_sram_req),
        .we_i    (w_sram_we),
        .addr_i  (w_sram_addr),
        .wdata_i (w_sram_wdata),
        .be_i    (w_sram_be),
        .rdata_o (w_sram_rdata)
    );

endmodule

// File: tb/tb_tc_sram_arbiter.sv
// Bench for tc_sram_arbiter: two instances (Latency 1 and 3) share stimulus and a transaction-level model.
module tb_tc_sram_arbiter;

    localparam int NR = 4;
    localparam int NW = 16;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [NR-1:0]    b_req;
    logic [NR-1:0]    b_we;
    logic [3:0]       b_addr  [NR];
    logic [DW-1:0]    b_wdata [NR];
    logic [7:0]       b_be    [NR];

    logic [NR-1:0]    w_req, w_we;
    logic [NR*4-1:0]  w_addr;
    logic [NR*DW-1:0] w_wdata;
    logic [NR*8-1:0]  w_be;

    assign w_req = b_req;
    assign w_we  = b_we;
    for (genvar gi = 0; gi < NR; gi++) begin : g_pack
        assign w_addr[gi*4 +: 4]    = b_addr[gi];
        assign w_wdata[gi*DW +: DW] = b_wdata[gi];
        assign w_be[gi*8 +: 8]      = b_be[gi];
    end

    logic [NR-1:0] gnt1, gnt3, rv1, rv3;
    logic [DW-1:0] rd1, rd3;
    logic          done1, done3;

    tc_sram_arbiter #(.NumReq(NR), .NumWords(NW), .DataWidth(DW), .ByteWidth(8),
                      .Latency(1), .InitZero(1'b1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(w_req), .we_i(w_we), .addr_i(w_addr),
        .wdata_i(w_wdata), .be_i(w_be), .gnt_o(gnt1), .rvalid_o(rv1), .rdata_o(rd1),
        .init_done_o(done1));

    tc_sram_arbiter #(.NumReq(NR), .NumWords(NW), .DataWidth(DW), .ByteWidth(8),
                      .Latency(3), .InitZero(1'b1)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(w_req), .we_i(w_we), .addr_i(w_addr),
        .wdata_i(w_wdata), .be_i(w_be), .gnt_o(gnt3), .rvalid_o(rv3), .rdata_o(rd3),
        .init_done_o(done3));

    // Reference model state
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            ptr = 0;
    logic [DW-1:0] m_mem [NW];
    int            lat [2] = '{1, 3};
    bit            s_vld [2][64];
    bit            s_rd  [2][64];
    int            s_id  [2][64];
    logic [DW-1:0] s_data[2][64];
    logic [NR-1:0] last_rv [2];
    logic [DW-1:0] last_rd [2];
    logic [NR-1:0] gseq[$];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        int            g;
        int            slot;
        bit            run;
        logic [NR-1:0] eg;
        logic [NR-1:0] erv;
        logic [NR-1:0] orv;
        logic [DW-1:0] ord;
        @(negedge clk);
        run = rst_n && (cyc > NW);
        g = -1;
        if (run) begin
            for (int k = 0; k < NR; k++) begin
                int j;
                j = (ptr + k) % NR;
                if (g < 0 && b_req[j]) g = j;
            end
        end
        eg = (g >= 0) ? NR'(1 << g) : '0;
        chk("gnt_L1", gnt1, eg);
        chk("gnt_L3", gnt3, eg);
        chk("init_done_L1", done1, run);
        chk("init_done_L3", done3, run);
        gseq.push_back(gnt1);
        for (int d = 0; d < 2; d++) begin
            slot = cyc % 64;
            orv  = (d == 0) ? rv1 : rv3;
            ord  = (d == 0) ? rd1 : rd3;
            erv  = s_vld[d][slot] ? NR'(1 << s_id[d][slot]) : '0;
            chk((d == 0) ? "rvalid_L1" : "rvalid_L3", orv, erv);
            if (s_vld[d][slot] && s_rd[d][slot])
                chk((d == 0) ? "rdata_L1" : "rdata_L3", ord, s_data[d][slot]);
            if (orv != '0) begin
                last_rv[d] = orv;
                last_rd[d] = ord;
            end
            s_vld[d][slot] = 1'b0;
        end
        if (g >= 0) begin
            ptr = (g + 1) % NR;
            for (int d = 0; d < 2; d++) begin
                slot = (cyc + lat[d]) % 64;
                s_vld[d][slot]  = 1'b1;
                s_id[d][slot]   = g;
                s_rd[d][slot]   = !b_we[g];
                s_data[d][slot] = m_mem[b_addr[g]];
            end
            if (b_we[g]) begin
                for (int b = 0; b < 8; b++)
                    if (b_be[g][b]) m_mem[b_addr[g]][b*8 +: 8] = b_wdata[g][b*8 +: 8];
            end
        end
        @(posedge clk);
        #1;
        if (g >= 0) b_req[g] = 1'b0;
        if (rst_n) cyc++;
    endtask

    task automatic issue(input int i, input bit we, input logic [3:0] a,
                         input logic [DW-1:0] d, input logic [7:0] be);
        b_req[i]   = 1'b1;
        b_we[i]    = we;
        b_addr[i]  = a;
        b_wdata[i] = d;
        b_be[i]    = be;
    endtask

    task automatic do_reset(input int hold);
        rst_n = 1'b0;
        b_req = '0;
        ptr   = 0;
        cyc   = 0;
        for (int d = 0; d < 2; d++)
            for (int s = 0; s < 64; s++) s_vld[d][s] = 1'b0;
        for (int a = 0; a < NW; a++) m_mem[a] = '0;
        repeat (hold) step();
        rst_n = 1'b1;
        cyc   = 1;
    endtask

    task automatic drain();
        for (int n = 0; n < 16 && b_req != '0; n++) step();
        repeat (4) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NR-1:0] exp2 [8];
        logic [NR-1:0] exp4 [3];
        exp2 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        exp4 = '{4'b0100, 4'b0001, 4'b0100};
        b_req = '0;
        b_we  = '0;
        for (int i = 0; i < NR; i++) begin
            b_addr[i] = '0; b_wdata[i] = '0; b_be[i] = '0;
            last_rv[i % 2] = '0; last_rd[i % 2] = '0;
        end

        // Reset, zero-fill with all masters already waiting, then round-robin order
        do_reset(3);
        for (int i = 0; i < NR; i++) issue(i, 1'b0, 4'(i * 3), '0, '0);
        repeat (NW) step();
        gseq.delete();
        for (int n = 0; n < 8; n++) begin
            step();
            for (int i = 0; i < NR; i++)
                if (!b_req[i]) issue(i, 1'b0, 4'($urandom_range(0, NW - 1)), '0, '0);
        end
        for (int n = 0; n < 8; n++) chk("rr_all_four", gseq[n], exp2[n]);
        drain();

        // Every word reads back as zero after the fill
        for (int a = 0; a < NW; a++) begin
            issue(0, 1'b0, 4'(a), '0, '0);
            step();
        end
        drain();

        // Byte-masked write then read from another master
        issue(1, 1'b1, 4'd5, 64'hFFFF_FFFF_DEAD_BEEF, 8'h0F);
        step();
        issue(3, 1'b0, 4'd5, '0, '0);
        step();
        drain();
        chk("bemask_rvalid_L1", last_rv[0], 4'b1000);
        chk("bemask_rdata_L1", last_rd[0], 64'h0000_0000_DEAD_BEEF);
        chk("bemask_rvalid_L3", last_rv[1], 4'b1000);
        chk("bemask_rdata_L3", last_rd[1], 64'h0000_0000_DEAD_BEEF);

        // Pointer wrap: req2 alone, then req0+req2 together
        gseq.delete();
        issue(2, 1'b0, 4'd1, '0, '0);
        step();
        issue(0, 1'b0, 4'd2, '0, '0);
        issue(2, 1'b0, 4'd3, '0, '0);
        step();
        step();
        for (int n = 0; n < 3; n++) chk("rr_wrap", gseq[n], exp4[n]);
        drain();

        // Random traffic against the model
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < NR; i++)
                if (!b_req[i] && $urandom_range(0, 1) == 1)
                    issue(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, NW - 1)),
                          {$urandom, $urandom}, 8'($urandom));
            step();
        end
        drain();

        // Reset in the middle of the fill, at word 7
        do_reset(2);
        repeat (7) step();
        do_reset(2);
        repeat (NW) step();
        step();

        // Reset with two reads in flight
        issue(0, 1'b0, 4'd4, '0, '0);
        issue(1, 1'b0, 4'd5, '0, '0);
        step();
        step();
        do_reset(3);
        repeat (NW + 1) step();
        issue(2, 1'b0, 4'd5, '0, '0);
        step();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
